axi_burst_master: RTL and testbench

- AXI-style burst master that drives the team's axi_ram slave through its AW/W/B/AR/R channel set.
- Accepts one command at a time (write or read, start address, beat count, burst type) on a valid/ready command port.
- Streams write data in and read data out on valid/ready side ports.
- Reports completion with a one-cycle done pulse carrying the accumulated response; replaces hand-coded bus tasks in system-level tests and serves as the front end for future DMA/loader blocks.

---
 rtl/axi_burst_pkg.sv | 30 +++
 rtl/axi_burst_master.sv | 208 ++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI burst master.
package axi_burst_pkg;

    // Master sequencing states: one command in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    // AXI response encodings, ordered by severity.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Burst type encodings, forwarded unchanged to the slave.
    localparam logic BURST_FIXED = 1'b0;
    localparam logic BURST_INCR  = 1'b1;

    // Accumulate the worst response seen so far (higher code = more severe).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-command AXI burst master: issues one AW/W/B or AR/R burst per
// accepted command and reports completion with a one-cycle done pulse.
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_burst,
    // write-data side port
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // read-data side port
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // write-address channel
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWBURST,
    output logic [7:0]            AWLEN,
    // write-data channel
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    // write-response channel
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // read-address channel
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARBURST,
    output logic [7:0]            ARLEN,
    // read-data channel
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST
);

    state_t                state_q, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic [7:0]            len_q, len_nx;
    logic                  burst_q, burst_nx;
    logic [7:0]            cnt_q, cnt_nx;
    logic [1:0]            resp_q, resp_nx;
    logic [1:0]            resp_beat;
    logic                  last_beat;

    // Beat counter reaches the final beat of the latched command.
    assign last_beat = (cnt_q == (len_q - 8'd1));

    // Address/len/burst are registered copies, stable for the whole command.
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWBURST = burst_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARBURST = burst_q;

    // Data buses pass straight through; only the handshakes are gated by state.
    assign WDATA   = wr_data;
    assign rd_data = RDATA;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_nx;
            addr_q  <= addr_nx;
            len_q   <= len_nx;
            burst_q <= burst_nx;
            cnt_q   <= cnt_nx;
            resp_q  <= resp_nx;
        end
    end

    // Next-state, datapath updates and handshake outputs per state.
    always_comb begin
        state_nx  = state_q;
        addr_nx   = addr_q;
        len_nx    = len_q;
        burst_nx  = burst_q;
        cnt_nx    = cnt_q;
        resp_nx   = resp_q;
        resp_beat = resp_q;
        cmd_ready = 1'b0;
        AWVALID   = 1'b0;
        ARVALID   = 1'b0;
        WVALID    = 1'b0;
        wr_ready  = 1'b0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        RREADY    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        done      = 1'b0;
        done_resp = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                // Reset forces every ready low, including the command port.
                cmd_ready = ~ARESET;
                if (cmd_valid) begin
                    if (cmd_len == 8'd0) begin
                        resp_nx  = RESP_SLVERR;
                        state_nx = ST_DONE;
                    end else begin
                        addr_nx  = cmd_addr;
                        len_nx   = cmd_len;
                        burst_nx = cmd_burst;
                        cnt_nx   = '0;
                        resp_nx  = RESP_OKAY;
                        state_nx = cmd_write ? ST_AW : ST_AR;
                    end
                end
            end

            ST_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    state_nx = ST_W;
                end
            end

            ST_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WLAST    = last_beat;
                if (wr_valid && WREADY) begin
                    cnt_nx = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_nx = ST_B;
                    end
                end
            end

            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    resp_nx  = resp_max(resp_q, BRESP);
                    state_nx = ST_DONE;
                end
            end

            ST_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_nx = ST_R;
                end
            end

            ST_R: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
                rd_last  = last_beat;
                if (RVALID && rd_ready) begin
                    resp_beat = resp_max(resp_q, RRESP);
                    // A slave RLAST that disagrees with our own count is flagged
                    // but never shortens or extends the burst.
                    if (RLAST != last_beat) begin
                        resp_beat = resp_max(resp_beat, RESP_SLVERR);
                    end
                    resp_nx = resp_beat;
                    cnt_nx  = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_nx = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                done_resp = resp_q;
                state_nx  = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a behavioural RAM slave model.
module tb_axi_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_burst;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;
    logic        AWVALID, AWREADY, AWBURST;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        WVALID, WREADY, WLAST;
    logic [31:0] WDATA;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY, ARBURST;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        RVALID, RREADY, RLAST;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    axi_burst_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    // slave model and stimulus configuration
    logic [31:0] mem [256];
    logic [31:0] wsrc [16];
    bit          stall;
    logic [1:0]  bresp_cfg;
    int          rresp_beat, rlast_bad_beat, rst_beat;
    logic [1:0]  rresp_val;

    // per-command observations
    logic [31:0] rd_got [16];
    logic [15:0] wlast_mask, rlast_mask;
    int          src_idx, wbeats, rbeats, done_cnt, done_cyc, activity;
    int          aw_unstable, ar_unstable;
    logic [1:0]  done_resp_got;
    logic [15:0] seen_addr;
    logic [7:0]  seen_len;
    logic        seen_burst;
    bit          aborted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
    endtask

    function automatic logic rnd();
        return stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // One command from handshake to done (or mid-burst reset), acting as
    // data source/sink and as the RAM slave, one cycle per loop pass.
    task automatic run_cmd(input logic wr, input logic [15:0] a, input logic [7:0] n,
                           input logic b, input int budget);
        bit aw_got = 0, ar_got = 0, b_pend = 0;
        bit aw_wait = 0, ar_wait = 0;
        logic [15:0] aw_a = '0, ar_a = '0, pa = '0, pra = '0;
        logic [7:0]  aw_n = '0, ar_n = '0, pn = '0, prn = '0;
        int w_idx = 0, r_idx = 0, cyc = 1;
        wlast_mask = '0; rlast_mask = '0; src_idx = 0; wbeats = 0; rbeats = 0;
        done_cnt = 0; done_cyc = -1; activity = 0; aw_unstable = 0; ar_unstable = 0;
        done_resp_got = 2'bxx; seen_addr = 'x; seen_len = 'x; seen_burst = 1'bx; aborted = 0;

        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n; cmd_burst = b;
        #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge ACLK);
        cmd_valid = 1'b0;

        while (done_cnt == 0 && !aborted && cyc < budget) begin
            AWREADY  = rnd();
            ARREADY  = rnd();
            wr_valid = (src_idx < int'(n)) && rnd();
            wr_data  = wsrc[src_idx & 15];
            WREADY   = aw_got && rnd();
            BVALID   = b_pend && rnd();
            BRESP    = bresp_cfg;
            RVALID   = ar_got && (r_idx < int'(ar_n)) && rnd();
            RDATA    = RVALID ? mem[(int'(ar_a) + r_idx) & 255] : '0;
            RRESP    = (RVALID && r_idx == rresp_beat) ? rresp_val : 2'b00;
            RLAST    = RVALID && ((r_idx == int'(ar_n) - 1) ^ (r_idx == rlast_bad_beat));
            rd_ready = rnd();

            if (rst_beat >= 0 && src_idx == rst_beat - 1) begin
                ARESET = 1'b1;
                #1;
                check("rst_mid_ctrl", {AWVALID, WVALID, wr_ready, BREADY, ARVALID, RREADY,
                                       rd_valid, cmd_ready, done, WLAST, rd_last}, '0);
                check("rst_mid_regs", {AWADDR, AWLEN, AWBURST, ARADDR, ARLEN, ARBURST, done_resp}, '0);
                aborted = 1;
            end else begin
                #1;
                if (AWVALID || ARVALID || WVALID || wr_ready || BREADY || RREADY || rd_valid)
                    activity++;
                if (aw_wait && AWVALID && (AWADDR !== pa || AWLEN !== pn)) aw_unstable++;
                if (ar_wait && ARVALID && (ARADDR !== pra || ARLEN !== prn)) ar_unstable++;
                aw_wait = AWVALID && !AWREADY; pa = AWADDR; pn = AWLEN;
                ar_wait = ARVALID && !ARREADY; pra = ARADDR; prn = ARLEN;

                if (AWVALID && AWREADY) begin
                    aw_got = 1; aw_a = AWADDR; aw_n = AWLEN; w_idx = 0;
                    seen_addr = AWADDR; seen_len = AWLEN; seen_burst = AWBURST;
                end
                if (ARVALID && ARREADY) begin
                    ar_got = 1; ar_a = ARADDR; ar_n = ARLEN; r_idx = 0;
                    seen_addr = ARADDR; seen_len = ARLEN; seen_burst = ARBURST;
                end
                if (wr_valid && wr_ready) src_idx++;
                if (WVALID && WREADY) begin
                    mem[(int'(aw_a) + w_idx) & 255] = WDATA;
                    if (WLAST) wlast_mask[w_idx & 15] = 1'b1;
                    w_idx++; wbeats++;
                    if (w_idx == int'(aw_n)) b_pend = 1;
                end
                if (BVALID && BREADY) b_pend = 0;
                if (RVALID && RREADY) r_idx++;
                if (rd_valid && rd_ready) begin
                    rd_got[rbeats & 15] = rd_data;
                    if (rd_last) rlast_mask[rbeats & 15] = 1'b1;
                    rbeats++;
                end
                if (done) begin
                    done_cnt++; done_cyc = cyc; done_resp_got = done_resp;
                end
                cyc++;
                @(negedge ACLK);
            end
        end

        drive_idle();
        if (aborted) begin
            @(negedge ACLK);
            ARESET = 1'b0;
        end else begin
            #1;
            check("done_pulse_width", {done, cmd_ready}, 2'b01);
        end
    endtask

    task automatic clear_cfg();
        stall = 0; bresp_cfg = 2'b00; rresp_beat = -1; rresp_val = 2'b00;
        rlast_bad_beat = -1; rst_beat = -1;
    endtask

    initial begin
        int quiet_done;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        clear_cfg();
        drive_idle();
        cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = 1'b0;

        // reset state
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        check("reset_outputs", {cmd_ready, AWVALID, WVALID, wr_ready, BREADY, ARVALID, RREADY,
                                rd_valid, done, AWADDR, AWLEN, ARADDR, ARLEN}, '0);
        ARESET = 1'b0;
        #1;
        check("idle_after_reset", {cmd_ready, done}, 2'b10);

        // write 0x5..0xE to addr 5, then read it back
        for (int i = 0; i < 10; i++) wsrc[i] = 32'(5 + i);
        run_cmd(1'b1, 16'h0005, 8'd10, 1'b1, 100);
        check("wr_awaddr", seen_addr, 16'h0005);
        check("wr_awlen", seen_len, 8'd10);
        check("wr_awburst", seen_burst, 1'b1);
        check("wr_beats", wbeats, 10);
        check("wr_wlast_mask", wlast_mask, 16'h0200);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_done_resp", done_resp_got, 2'b00);
        check("wr_latency", done_cyc, 13);

        run_cmd(1'b0, 16'h0005, 8'd10, 1'b1, 100);
        check("rd_araddr", seen_addr, 16'h0005);
        check("rd_arlen", seen_len, 8'd10);
        check("rd_beats", rbeats, 10);
        for (int i = 0; i < 10; i++) check($sformatf("rd_data%0d", i), rd_got[i], 32'(5 + i));
        check("rd_last_mask", rlast_mask, 16'h0200);
        check("rd_done_resp", done_resp_got, 2'b00);
        check("rd_latency", done_cyc, 12);

        // backpressure on every interface, len 4
        stall = 1;
        for (int i = 0; i < 4; i++) wsrc[i] = 32'hA0 + 32'(i);
        run_cmd(1'b1, 16'h0040, 8'd4, 1'b1, 500);
        check("bp_wr_beats", wbeats, 4);
        check("bp_wr_src_beats", src_idx, 4);
        check("bp_wlast_mask", wlast_mask, 16'h0008);
        check("bp_aw_stable", aw_unstable, 0);
        check("bp_wr_resp", {done_cnt[1:0], done_resp_got}, 4'b0100);
        run_cmd(1'b0, 16'h0040, 8'd4, 1'b1, 500);
        check("bp_rd_beats", rbeats, 4);
        for (int i = 0; i < 4; i++) check($sformatf("bp_rd_data%0d", i), rd_got[i], 32'hA0 + 32'(i));
        check("bp_rlast_mask", rlast_mask, 16'h0008);
        check("bp_ar_stable", ar_unstable, 0);
        check("bp_rd_resp", {done_cnt[1:0], done_resp_got}, 4'b0100);
        clear_cfg();

        // zero length: no bus activity, SLVERR on the very next cycle
        run_cmd(1'b1, 16'h0077, 8'd0, 1'b1, 20);
        check("zl_activity", activity, 0);
        check("zl_latency", done_cyc, 1);
        check("zl_resp", done_resp_got, 2'b10);

        // error responses
        bresp_cfg = 2'b10;
        wsrc[0] = 32'h11; wsrc[1] = 32'h22;
        run_cmd(1'b1, 16'h0060, 8'd2, 1'b1, 100);
        check("err_bresp", done_resp_got, 2'b10);
        clear_cfg();
        rresp_beat = 1; rresp_val = 2'b11;
        run_cmd(1'b0, 16'h0005, 8'd3, 1'b1, 100);
        check("err_rresp", done_resp_got, 2'b11);
        check("err_rd_beats", rbeats, 3);
        check("err_rd_data2", rd_got[2], 32'h7);
        clear_cfg();

        // early RLAST on beat 2 of a len-4 read
        rlast_bad_beat = 1;
        run_cmd(1'b0, 16'h0005, 8'd4, 1'b1, 100);
        check("rlast_beats", rbeats, 4);
        check("rlast_rd_last_mask", rlast_mask, 16'h0008);
        check("rlast_resp", done_resp_got, 2'b10);
        clear_cfg();

        // reset during beat 3 of a len-8 write
        rst_beat = 3;
        for (int i = 0; i < 8; i++) wsrc[i] = 32'hC0 + 32'(i);
        run_cmd(1'b1, 16'h0010, 8'd8, 1'b1, 100);
        check("rst_aborted", aborted, 1'b1);
        check("rst_no_done", done_cnt, 0);
        clear_cfg();
        quiet_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            #1;
            if (done) quiet_done++;
        end
        check("rst_quiet_done", quiet_done, 0);
        wsrc[0] = 32'h33; wsrc[1] = 32'h44;
        run_cmd(1'b1, 16'h0030, 8'd2, 1'b1, 100);
        check("post_rst_beats", wbeats, 2);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_resp", done_resp_got, 2'b00);
        check("post_rst_mem", {mem[8'h30], mem[8'h31]}, {32'h33, 32'h44});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
